// File: rtl/mul_share_pkg.sv
// Shared constants, types and helpers for the shared 8x8 multiplier arbiter.
// Operand/product widths, the packed request record and the requester-index width helper.
package mul_share_pkg;

   localparam int OPW   = 8;
   localparam int PRODW = 16;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
   } mul_req_t;

   // max(1, clog2(n)): a single requester still gets a one-bit index
   function automatic int id_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arb_core.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// grant_any/gnt_idx ignore en; the one-hot grant is only asserted when en is high.
module rr_arb_core
   import mul_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_any
);

   logic [2*NREQ-1:0] rot;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt     = '0;
      // rotating a doubled copy puts the pointer position at bit 0
      rot     = {req, req} >> ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_any && rot[k]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'((int'(ptr) + k) % NREQ);
         end
      end
      if (en && gnt_any) gnt = NREQ'(1) << gnt_idx;
   end

endmodule

// File: rtl/mul8u_share_arb.sv
// Shares one external combinational 8x8 unsigned multiplier among NREQ requesters
// with round-robin arbitration and a single backpressured result register.
module mul8u_share_arb
   import mul_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = id_width(NREQ),
   parameter int CNTW = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*OPW-1:0]  req_a,
   input  logic [NREQ*OPW-1:0]  req_b,
   output logic [OPW-1:0]       mul_a,
   output logic [OPW-1:0]       mul_b,
   input  logic [PRODW-1:0]     mul_o,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [PRODW-1:0]     rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic [CNTW-1:0]      op_count
);

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] idx);
      return (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
   endfunction

   mul_req_t         req_arr [NREQ];
   mul_req_t         sel;
   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_any;
   logic             can_accept;
   logic             accept;
   logic             drain;

   logic             vld_p1;
   logic [PRODW-1:0] data_p1;
   logic [IDW-1:0]   id_p1;
   logic [IDW-1:0]   ptr;
   logic [CNTW-1:0]  cnt;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_arr[i].a = req_a[i*OPW +: OPW];
         req_arr[i].b = req_b[i*OPW +: OPW];
      end
   end

   // non-owner rsp_ready bits are deliberately ignored by indexing with id_p1
   assign drain      = vld_p1 && rsp_ready[id_p1];
   assign can_accept = !vld_p1 || rsp_ready[id_p1];

   rr_arb_core #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .en      (can_accept),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign req_ready = gnt;
   assign accept    = gnt_any && can_accept;

   // operands stay at zero when nobody is requesting, so the multiplier does not toggle
   assign sel   = req_arr[gnt_idx];
   assign mul_a = gnt_any ? sel.a : '0;
   assign mul_b = gnt_any ? sel.b : '0;

   // p1: result register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         id_p1   <= '0;
         ptr     <= '0;
         cnt     <= '0;
      end else begin
         if (accept) begin
            vld_p1  <= 1'b1;
            data_p1 <= mul_o;
            id_p1   <= gnt_idx;
            ptr     <= ptr_next(gnt_idx);
         end else if (drain) begin
            vld_p1  <= 1'b0;
         end
         if (drain) cnt <= sat_inc(cnt);
      end
   end

   assign rsp_valid = vld_p1 ? (NREQ'(1) << id_p1) : '0;
   assign rsp_data  = data_p1;
   assign rsp_id    = id_p1;
   assign op_count  = cnt;

endmodule

// File: tb/tb_mul8u_share_arb.sv
// Bench for mul8u_share_arb: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, the result register and the counter.
module tb_mul8u_share_arb;

   localparam int N = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        approx;
   logic [3:0]  req_valid, rsp_ready;
   logic [7:0]  op_a [N];
   logic [7:0]  op_b [N];
   logic [31:0] req_a, req_b;

   logic [3:0]  req_ready, rsp_valid;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_o, rsp_data, op_count;
   logic [1:0]  rsp_id;

   logic [3:0]  s_req_ready, s_rsp_valid, s_op_count;
   logic [7:0]  s_mul_a, s_mul_b;
   logic [15:0] s_mul_o, s_rsp_data;
   logic [1:0]  s_rsp_id;

   assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
   assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

   // external multiplier: exact, or an approximate variant that corrupts low bits
   function automatic logic [15:0] ext_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic ap);
      logic [15:0] p;
      p = 16'(a) * 16'(b);
      return ap ? (p ^ {8'h00, a[3:0], b[3:0]}) : p;
   endfunction

   assign mul_o   = ext_mul(mul_a, mul_b, approx);
   assign s_mul_o = ext_mul(s_mul_a, s_mul_b, approx);

   mul8u_share_arb #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .op_count(op_count)
   );

   mul8u_share_arb #(.NREQ(4), .IDW(2), .CNTW(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
      .req_a(req_a), .req_b(req_b), .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_o(s_mul_o),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
      .rsp_id(s_rsp_id), .op_count(s_op_count)
   );

   int total = 0;
   int bad   = 0;

   bit          m_vld;
   int          m_id, m_ptr, m_cnt, m_cnt_s, last_acc;
   logic [15:0] m_data;

   task automatic model_reset();
      m_vld = 0; m_id = 0; m_ptr = 0; m_cnt = 0; m_cnt_s = 0; m_data = '0; last_acc = -1;
   endtask

   // Check the current cycle against the model, then advance one clock.
   task automatic step();
      int g;
      bit can, acc, drn;
      logic [3:0] er, ev;
      logic [7:0] ea, eb;
      #1;
      can = !m_vld || rsp_ready[m_id];
      g = -1;
      for (int k = 0; k < N; k++)
         if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      er = '0;
      if (can && g >= 0) er[g] = 1'b1;
      ea = (g >= 0) ? op_a[g] : 8'd0;
      eb = (g >= 0) ? op_b[g] : 8'd0;
      ev = '0;
      if (m_vld) ev[m_id] = 1'b1;

      total++; if (req_ready !== er) begin bad++; $display("FAIL req_ready got=%b exp=%b", req_ready, er); end
      total++; if (mul_a !== ea) begin bad++; $display("FAIL mul_a got=%0d exp=%0d", mul_a, ea); end
      total++; if (mul_b !== eb) begin bad++; $display("FAIL mul_b got=%0d exp=%0d", mul_b, eb); end
      total++; if (rsp_valid !== ev) begin bad++; $display("FAIL rsp_valid got=%b exp=%b", rsp_valid, ev); end
      if (m_vld) begin
         total++; if (rsp_data !== m_data) begin bad++; $display("FAIL rsp_data got=%0d exp=%0d", rsp_data, m_data); end
         total++; if (rsp_id !== 2'(m_id)) begin bad++; $display("FAIL rsp_id got=%0d exp=%0d", rsp_id, m_id); end
      end
      total++; if (op_count !== 16'(m_cnt)) begin bad++; $display("FAIL op_count got=%0d exp=%0d", op_count, m_cnt); end
      total++; if (s_op_count !== 4'(m_cnt_s)) begin bad++; $display("FAIL op_count_sat got=%0d exp=%0d", s_op_count, m_cnt_s); end

      acc = can && (g >= 0);
      drn = m_vld && rsp_ready[m_id];
      last_acc = -1;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (drn) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
         end
         if (acc) begin
            m_vld = 1; m_id = g; m_data = ext_mul(op_a[g], op_b[g], approx);
            m_ptr = (g + 1) % N; last_acc = g;
         end else if (drn) begin
            m_vld = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      op_a[i] = a; op_b[i] = b; req_valid[i] = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; approx = 1'b0; req_valid = '0; rsp_ready = '0;
      for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
      @(posedge clk); @(negedge clk);
      total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
      total++; if (rsp_data !== 16'd0) begin bad++; $display("FAIL reset_rsp_data got=%0d exp=0", rsp_data); end
      total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
      total++; if (op_count !== 16'd0) begin bad++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
      total++; if (s_op_count !== 4'd0) begin bad++; $display("FAIL reset_op_count_sat got=%0d exp=0", s_op_count); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      rsp_ready = 4'hF;
      set_req(0, 8'd200, 8'd100);
      step();
      req_valid = '0;
      total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_valid got=%b exp=0001", rsp_valid); end
      total++; if (rsp_data !== 16'd20000) begin bad++; $display("FAIL single_data got=%0d exp=20000", rsp_data); end
      total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
      step();
      total++; if (op_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", op_count); end
      total++; if (rsp_valid !== 4'b0) begin bad++; $display("FAIL single_drain got=%b exp=0000", rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [3:0] e;
      do_reset();
      rsp_ready = 4'hF;
      for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
      for (int k = 0; k < 8; k++) begin
         #1;
         e = 4'b0001 << (k % 4);
         total++; if (req_ready !== e) begin bad++; $display("FAIL rr_order cycle=%0d got=%b exp=%b", k, req_ready, e); end
         step();
         if (last_acc >= 0) begin op_a[last_acc] = 8'($urandom); op_b[last_acc] = 8'($urandom); end
      end
      req_valid = '0;
      step();
      total++; if (op_count !== 16'd8) begin bad++; $display("FAIL rr_count got=%0d exp=8", op_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      rsp_ready = 4'hF;
      set_req(2, 8'd255, 8'd255);
      step();
      req_valid = '0;
      rsp_ready = 4'b1011;
      set_req(0, 8'd3, 8'd4);
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (rsp_data !== 16'd65025) begin bad++; $display("FAIL bp_hold_data got=%0d exp=65025", rsp_data); end
         total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL bp_hold_valid got=%b exp=0100", rsp_valid); end
         total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL bp_req_ready got=%b exp=0000", req_ready); end
      end
      rsp_ready = 4'b0100;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_refill got=%b exp=0001", req_ready); end
      step();
      req_valid = '0;
      total++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'd12) begin
         bad++; $display("FAIL bp_next got=%b/%0d exp=0001/12", rsp_valid, rsp_data);
      end
      rsp_ready = 4'hF;
      step();
   endtask

   task automatic test_mid_reset();
      do_reset();
      rsp_ready = 4'hF;
      set_req(1, 8'd7, 8'd9);
      step();
      req_valid = '0;
      set_req(2, 8'd5, 8'd5);
      step();
      req_valid = '0; rsp_ready = '0;
      step();
      total++; if (op_count !== 16'd1 || rsp_valid !== 4'b0100) begin
         bad++; $display("FAIL mid_pre got=%0d/%b exp=1/0100", op_count, rsp_valid);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      total++; if (rsp_valid !== 4'b0 || op_count !== 16'd0) begin
         bad++; $display("FAIL mid_reset got=%b/%0d exp=0000/0", rsp_valid, op_count);
      end
      set_req(3, 8'd11, 8'd2);
      set_req(0, 8'd6, 8'd6);
      rsp_ready = 4'hF;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b exp=0001", req_ready); end
      step();
      req_valid[0] = 1'b0;
      step();
      req_valid = '0;
      step();
   endtask

   task automatic test_idle_approx();
      do_reset();
      approx = 1'b1;
      #1;
      total++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin
         bad++; $display("FAIL idle_ops got=%0d/%0d exp=0/0", mul_a, mul_b);
      end
      set_req(1, 8'd13, 8'd77);
      rsp_ready = 4'hF;
      #1;
      total++; if (mul_a !== 8'd13 || mul_b !== 8'd77) begin
         bad++; $display("FAIL drive_ops got=%0d/%0d exp=13/77", mul_a, mul_b);
      end
      step();
      req_valid = '0;
      total++; if (rsp_data !== 16'd820) begin bad++; $display("FAIL approx_data got=%0d exp=820", rsp_data); end
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rsp_ready = 4'($urandom);
         if (c % 50 == 0) approx = 1'($urandom);
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && ($urandom % 3 == 0)) set_req(i, 8'($urandom), 8'($urandom));
            else if (req_valid[i] && ($urandom % 16 == 0)) req_valid[i] = 1'b0;
         end
         step();
         if (last_acc >= 0) req_valid[last_acc] = 1'b0;
      end
      req_valid = '0; rsp_ready = 4'hF;
      step();
      approx = 1'b0;
   endtask

   task automatic test_saturation();
      do_reset();
      rsp_ready = 4'hF;
      for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom));
      for (int k = 0; k < 20; k++) step();
      req_valid = '0;
      step();
      total++; if (op_count !== 16'd20) begin bad++; $display("FAIL sat_wide got=%0d exp=20", op_count); end
      total++; if (s_op_count !== 4'd15) begin bad++; $display("FAIL sat_narrow got=%0d exp=15", s_op_count); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_mid_reset();
      test_idle_approx();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
